alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_if.sv | 20 ++
 rtl/alu_shifter.sv | 64 ++++++
 rtl/alu.sv | 191 +++++++++++++++++++
 tb/tb_alu.sv | 122 ++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, flag bit positions, flag record
// and the shifter operation kinds.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD = 5'b00000,
      OP_SUB = 5'b00001,
      OP_AND = 5'b00010,
      OP_OR  = 5'b00011,
      OP_XOR = 5'b00100,
      OP_NOT = 5'b00101,
      OP_LSL = 5'b00110,
      OP_LSR = 5'b00111,
      OP_ASR = 5'b01000,
      OP_ROL = 5'b01001,
      OP_ROR = 5'b01010,
      OP_MUL = 5'b01011,
      OP_DIV = 5'b01100,
      OP_MOD = 5'b01101,
      OP_CMP = 5'b01110,
      OP_TST = 5'b01111,
      OP_INC = 5'b10000,
      OP_DEC = 5'b10001,
      OP_MOV = 5'b10010,
      OP_NEG = 5'b10011
   } alu_op_t;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Member order gives z at bit 3 down to v at bit 0 when packed.
   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [2:0] {
      SH_LSL = 3'd0,
      SH_LSR = 3'd1,
      SH_ASR = 3'd2,
      SH_ROL = 3'd3,
      SH_ROR = 3'd4
   } shift_kind_t;

endpackage

// File: rtl/alu_if.sv
// ALU operand/result/flags bundle; the master drives operation and operands.
interface alu_if #(parameter int W = 16);

   logic [4:0]   alu_op;
   logic [W-1:0] operandA;
   logic [W-1:0] operandB;
   logic [W-1:0] resultAccumulator;
   logic [3:0]   flags;

   modport master (
      output alu_op, operandA, operandB,
      input  resultAccumulator, flags
   );

   modport slave (
      input  alu_op, operandA, operandB,
      output resultAccumulator, flags
   );

endinterface

// File: rtl/alu_shifter.sv
// Logical/arithmetic shifts and rotates; carry is the last bit shifted out
// (0 when nothing is shifted).
module alu_shifter
   import alu_pkg::*;
#(
   parameter  int W  = 16,
   localparam int AW = $clog2(W)
) (
   input  logic [W-1:0]  value,
   input  logic [AW-1:0] amount,
   input  shift_kind_t   kind,
   output logic [W-1:0]  result,
   output logic          carry
);

   logic [W:0]        lsl_ext;
   logic [W:0]        lsr_ext;
   logic signed [W:0] asr_ext;
   logic [AW-1:0]     rot_amt;
   logic [W-1:0]      rol_res;
   logic [W-1:0]      ror_res;

   // One guard bit beyond the data catches the last bit shifted out.
   assign lsl_ext = {1'b0, value} << amount;
   assign lsr_ext = {value, 1'b0} >> amount;
   assign asr_ext = $signed({value, 1'b0}) >>> amount;

   // Reduces only when W is not a power of two and amount can reach past W.
   assign rot_amt = AW'(int'(amount) % W);
   assign rol_res = (value << rot_amt) | (value >> (W - int'(rot_amt)));
   assign ror_res = (value >> rot_amt) | (value << (W - int'(rot_amt)));

   always_comb begin
      result = value;
      carry  = 1'b0;
      case (kind)
         SH_LSL: begin
            result = lsl_ext[W-1:0];
            carry  = lsl_ext[W];
         end
         SH_LSR: begin
            result = lsr_ext[W:1];
            carry  = lsr_ext[0];
         end
         SH_ASR: begin
            result = asr_ext[W:1];
            carry  = asr_ext[0];
         end
         SH_ROL: begin
            result = rol_res;
            carry  = (amount != '0) & rol_res[0];
         end
         SH_ROR: begin
            result = ror_res;
            carry  = (amount != '0) & ror_res[W-1];
         end
         default: begin
            result = value;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu.sv
// Combinational W-bit ALU with a registered Z/N/C/V flags register.
// Define ALU_MULDIV_EN to build MUL/DIV/MOD; otherwise those opcodes are illegal.
module alu
   import alu_pkg::*;
#(
   parameter int W = 16
) (
   input logic  clk,
   input logic  rst,
   alu_if.slave bus
);

   localparam int AW = $clog2(W);
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};

   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W:0]   add_ext;
   logic [W:0]   sub_ext;
   logic [W:0]   inc_ext;
   logic [W:0]   dec_ext;
   logic [W:0]   neg_ext;
   logic         add_ovf;
   logic         sub_ovf;

   shift_kind_t  sh_kind;
   logic [W-1:0] sh_res;
   logic         sh_carry;

   logic [W-1:0] res;
   logic [W-1:0] alt_src;
   logic         use_alt;
   logic [W-1:0] fsrc;
   logic         c_nxt;
   logic         v_nxt;
   logic         load;
   flags_t       flags_nxt;
   flags_t       flags_q;

   assign a = bus.operandA;
   assign b = bus.operandB;

   assign add_ext = {1'b0, a} + {1'b0, b};
   assign sub_ext = {1'b0, a} - {1'b0, b};
   assign inc_ext = {1'b0, a} + (W+1)'(1);
   assign dec_ext = {1'b0, a} - (W+1)'(1);
   assign neg_ext = (W+1)'(0) - {1'b0, a};

   assign add_ovf = (a[W-1] == b[W-1]) && (add_ext[W-1] != a[W-1]);
   assign sub_ovf = (a[W-1] != b[W-1]) && (sub_ext[W-1] != a[W-1]);

`ifdef ALU_MULDIV_EN
   logic [2*W-1:0] prod;
   logic           mul_ovf;
   logic           div_zero;
   logic           div_ovf;
   logic [W-1:0]   quot;
   logic [W-1:0]   rem;

   assign prod     = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
   assign mul_ovf  = prod[2*W-1:W] != {W{prod[W-1]}};
   assign div_zero = (b == '0);
   assign div_ovf  = (a == MIN_VAL) && (b == '1);

   // The two corner cases never reach the divider, so it never sees /0 or MIN/-1.
   always_comb begin
      quot = '0;
      rem  = '0;
      if (div_zero) begin
         quot = '0;
         rem  = '0;
      end else if (div_ovf) begin
         quot = MIN_VAL;
         rem  = '0;
      end else begin
         quot = $signed(a) / $signed(b);
         rem  = $signed(a) % $signed(b);
      end
   end
`endif

   always_comb begin
      sh_kind = SH_LSL;
      case (bus.alu_op)
         OP_LSR:  sh_kind = SH_LSR;
         OP_ASR:  sh_kind = SH_ASR;
         OP_ROL:  sh_kind = SH_ROL;
         OP_ROR:  sh_kind = SH_ROR;
         default: sh_kind = SH_LSL;
      endcase
   end

   alu_shifter #(.W(W)) u_shifter (
      .value  (a),
      .amount (b[AW-1:0]),
      .kind   (sh_kind),
      .result (sh_res),
      .carry  (sh_carry)
   );

   always_comb begin
      res     = '0;
      alt_src = '0;
      use_alt = 1'b0;
      c_nxt   = 1'b0;
      v_nxt   = 1'b0;
      load    = 1'b1;
      case (bus.alu_op)
         OP_ADD: begin
            res   = add_ext[W-1:0];
            c_nxt = add_ext[W];
            v_nxt = add_ovf;
         end
         OP_SUB: begin
            res   = sub_ext[W-1:0];
            c_nxt = sub_ext[W];
            v_nxt = sub_ovf;
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_NOT: res = ~a;
         OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
            res   = sh_res;
            c_nxt = sh_carry;
         end
`ifdef ALU_MULDIV_EN
         OP_MUL: begin
            res   = prod[W-1:0];
            v_nxt = mul_ovf;
         end
         OP_DIV: begin
            res   = quot;
            v_nxt = div_zero | div_ovf;
         end
         OP_MOD: begin
            res   = rem;
            v_nxt = div_zero;
         end
`endif
         OP_CMP: begin
            res     = a;
            alt_src = sub_ext[W-1:0];
            use_alt = 1'b1;
            c_nxt   = sub_ext[W];
            v_nxt   = sub_ovf;
         end
         OP_TST: begin
            res     = a;
            alt_src = a & b;
            use_alt = 1'b1;
         end
         OP_INC: begin
            res   = inc_ext[W-1:0];
            c_nxt = inc_ext[W];
            v_nxt = (a == MAX_VAL);
         end
         OP_DEC: begin
            res   = dec_ext[W-1:0];
            c_nxt = dec_ext[W];
            v_nxt = (a == MIN_VAL);
         end
         OP_MOV: res = b;
         OP_NEG: begin
            res   = neg_ext[W-1:0];
            c_nxt = neg_ext[W];
            v_nxt = (a == MIN_VAL);
         end
         default: load = 1'b0;
      endcase

      fsrc        = use_alt ? alt_src : res;
      flags_nxt.z = (fsrc == '0);
      flags_nxt.n = fsrc[W-1];
      flags_nxt.c = c_nxt;
      flags_nxt.v = v_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= '0;
      end else if (load) begin
         flags_q <= flags_nxt;
      end
   end

   assign bus.resultAccumulator = res;
   assign bus.flags             = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU at W=16; expected values are hand-computed.
module tb_alu;
   import alu_pkg::*;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [3:0] last_flags = 4'b0000;

   alu_if #(.W(W)) bus ();

   alu #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.alu_op   = op;
      bus.operandA = a;
      bus.operandB = b;
      #1;
   endtask

   task automatic step(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_res,
                       input logic [3:0] exp_flags);
      drive(op, a, b);
      check({tag, " res"}, bus.resultAccumulator, exp_res);
      @(posedge clk);
      #1;
      check({tag, " flags"}, W'(bus.flags), W'(exp_flags));
      last_flags = exp_flags;
   endtask

   initial begin
      rst          = 1'b1;
      bus.alu_op   = OP_INC;
      bus.operandA = 16'h0005;
      bus.operandB = 16'h0000;
      #7;
      check("reset flags", W'(bus.flags), W'(4'b0000));
      check("inc 5 in reset", bus.resultAccumulator, 16'h0006);

      drive(OP_INC, 16'hFFE0, 16'h0000);
      check("inc -32", bus.resultAccumulator, 16'hFFE1);
      drive(OP_INC, 16'h0000, 16'h0000);
      check("inc 0", bus.resultAccumulator, 16'h0001);
      drive(OP_INC, 16'h0064, 16'h0000);
      check("inc 100", bus.resultAccumulator, 16'h0065);
      check("flags held in reset", W'(bus.flags), W'(4'b0000));

      @(negedge clk);
      rst = 1'b0;

      //    tag            op      A         B         result    ZNCV
      step("inc max",     OP_INC, 16'h7FFF, 16'h0000, 16'h8000, 4'b0101);
      step("add -1+1",    OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
      step("cmp 5,7",     OP_CMP, 16'h0005, 16'h0007, 16'h0005, 4'b0110);
      step("sub min-1",   OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
      step("add max+1",   OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
      step("and",         OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000);
      step("or",          OP_OR,  16'h1200, 16'h0034, 16'h1234, 4'b0000);
      step("xor",         OP_XOR, 16'hAAAA, 16'hFFFF, 16'h5555, 4'b0000);
      step("not",         OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 4'b0100);
      step("lsl hi B",    OP_LSL, 16'h8001, 16'hFFF1, 16'h0002, 4'b0010);
      step("lsr",         OP_LSR, 16'h0003, 16'h0002, 16'h0000, 4'b1010);
      step("asr",         OP_ASR, 16'h8000, 16'h0004, 16'hF800, 4'b0100);
      step("rol",         OP_ROL, 16'h9000, 16'h0001, 16'h2001, 4'b0010);
      step("ror",         OP_ROR, 16'h0001, 16'h0001, 16'h8000, 4'b0110);
      step("tst",         OP_TST, 16'h00F0, 16'h0F00, 16'h00F0, 4'b1000);
      step("dec 0",       OP_DEC, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110);
      step("dec min",     OP_DEC, 16'h8000, 16'h0000, 16'h7FFF, 4'b0001);
      step("neg min",     OP_NEG, 16'h8000, 16'h0000, 16'h8000, 4'b0111);
      step("mov 0",       OP_MOV, 16'h1111, 16'h0000, 16'h0000, 4'b1000);
      step("neg 5",       OP_NEG, 16'h0005, 16'h0000, 16'hFFFB, 4'b0110);

      // Asynchronous reset asserted between edges with nonzero flags.
      #2;
      rst = 1'b1;
      #1;
      check("async rst flags", W'(bus.flags), W'(4'b0000));
      check("res under rst", bus.resultAccumulator, 16'hFFFB);
      @(negedge clk);
      rst = 1'b0;
      last_flags = 4'b0000;

      step("add after rst", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
      step("illegal 11111", 5'b11111, 16'h1234, 16'h5678, 16'h0000, last_flags);
      step("illegal 10100", 5'b10100, 16'h7FFF, 16'h0001, 16'h0000, last_flags);

`ifdef ALU_MULDIV_EN
      step("div by 0",    OP_DIV, 16'h000A, 16'h0000, 16'h0000, 4'b1001);
      step("mul ovf",     OP_MUL, 16'h012C, 16'h012C, 16'h5F90, 4'b0001);
      step("div -7/2",    OP_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 4'b0100);
      step("mod -7%2",    OP_MOD, 16'hFFF9, 16'h0002, 16'hFFFF, 4'b0100);
      step("div min/-1",  OP_DIV, 16'h8000, 16'hFFFF, 16'h8000, 4'b0101);
`else
      step("div by 0",    OP_DIV, 16'h000A, 16'h0000, 16'h0000, last_flags);
      step("mul off",     OP_MUL, 16'h012C, 16'h012C, 16'h0000, last_flags);
      step("mod off",     OP_MOD, 16'hFFF9, 16'h0002, 16'h0000, last_flags);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
